// File: rtl/em_box_renderer.sv
// Renders a solid square that bounces around the active area, one move per frame,
// behind a fixed 2-cycle pipeline that keeps colour aligned with the delayed syncs.
module em_box_renderer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned STEP     = 2,
  parameter logic [23:0] FG_COLOR = 24'hFF_FF_00,
  parameter logic [23:0] BG_COLOR = 24'h00_00_40
) (
  input  logic        pll_clk,
  input  logic        reset_P,
  input  logic [11:0] horz_count,
  input  logic [11:0] vert_count,
  input  logic        horz_sync,
  input  logic        vert_sync,
  input  logic        v_on,
  input  logic        pause,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [15:0] frame_count
);

  localparam logic [12:0] HA   = 13'(H_ACTIVE);
  localparam logic [12:0] VA   = 13'(V_ACTIVE);
  localparam logic [12:0] BS   = 13'(BOX_SIZE);
  localparam logic [12:0] ST   = 13'(STEP);
  localparam logic [12:0] HMAX = 13'(H_ACTIVE - BOX_SIZE);
  localparam logic [12:0] VMAX = 13'(V_ACTIVE - BOX_SIZE);

  typedef enum logic {RUN, PAUSED} state_t;

  state_t      state_q;
  logic [11:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [15:0] frame_count_q;

  logic        hs1_q, vs1_q, von1_q, inside1_q, inside_d;
  logic        hs2_q, vs2_q, von2_q;
  logic [23:0] rgb_q, rgb_d;

  logic        tick;
  logic [12:0] nx, ny, hx, vy, bx, by;

  assign tick = (horz_count == '0) && ({1'b0, vert_count} == VA);

  // Next position assuming a move happens; 13-bit sums cannot overflow.
  always_comb begin
    nx      = {1'b0, box_x_q} + ST;
    ny      = {1'b0, box_y_q} + ST;
    box_x_d = box_x_q;
    dx_d    = dx_q;
    box_y_d = box_y_q;
    dy_d    = dy_q;
    if (!dx_q) begin
      if (nx + BS >= HA) begin
        box_x_d = HMAX[11:0];
        dx_d    = 1'b1;
      end else begin
        box_x_d = nx[11:0];
      end
    end else if ({1'b0, box_x_q} <= ST) begin
      box_x_d = '0;
      dx_d    = 1'b0;
    end else begin
      box_x_d = box_x_q - ST[11:0];
    end
    if (!dy_q) begin
      if (ny + BS >= VA) begin
        box_y_d = VMAX[11:0];
        dy_d    = 1'b1;
      end else begin
        box_y_d = ny[11:0];
      end
    end else if ({1'b0, box_y_q} <= ST) begin
      box_y_d = '0;
      dy_d    = 1'b0;
    end else begin
      box_y_d = box_y_q - ST[11:0];
    end
  end

  // Entering PAUSED suppresses the move; leaving it moves on the same tick.
  always_ff @(posedge pll_clk) begin
    if (reset_P) begin
      state_q       <= RUN;
      box_x_q       <= '0;
      box_y_q       <= '0;
      dx_q          <= 1'b0;
      dy_q          <= 1'b0;
      frame_count_q <= '0;
    end else if (tick) begin
      frame_count_q <= frame_count_q + 16'd1;
      if (pause) begin
        state_q <= PAUSED;
      end else begin
        state_q <= RUN;
        box_x_q <= box_x_d;
        box_y_q <= box_y_d;
        dx_q    <= dx_d;
        dy_q    <= dy_d;
      end
    end
  end

  always_comb begin
    hx       = {1'b0, horz_count};
    vy       = {1'b0, vert_count};
    bx       = {1'b0, box_x_q};
    by       = {1'b0, box_y_q};
    inside_d = (hx >= bx) && (hx < bx + BS) && (vy >= by) && (vy < by + BS);
  end

  always_comb begin
    rgb_d = '0;
    if (von1_q) rgb_d = inside1_q ? FG_COLOR : BG_COLOR;
  end

  always_ff @(posedge pll_clk) begin
    if (reset_P) begin
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      von1_q    <= 1'b0;
      inside1_q <= 1'b0;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      von2_q    <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs1_q     <= horz_sync;
      vs1_q     <= vert_sync;
      von1_q    <= v_on;
      inside1_q <= inside_d;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      von2_q    <= von1_q;
      rgb_q     <= rgb_d;
    end
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_BLANK_N = von2_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_em_box_renderer.sv
// Directed + randomized bench for em_box_renderer; a per-tick position model
// predicts box placement, frame count and pixel colours.
module tb_em_box_renderer;

  localparam int HA = 640;
  localparam int VA = 480;
  localparam int BS = 32;
  localparam int ST = 2;
  localparam logic [23:0] FG = 24'hFFFF00;
  localparam logic [23:0] BG = 24'h000040;

  logic        pll_clk = 1'b0;
  logic        reset_P;
  logic [11:0] horz_count, vert_count;
  logic        horz_sync, vert_sync, v_on, pause;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int mx, my, mfc;
  bit mdx, mdy;

  always #5 pll_clk = ~pll_clk;

  em_box_renderer #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .BOX_SIZE(BS), .STEP(ST),
    .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .pll_clk(pll_clk), .reset_P(reset_P),
    .horz_count(horz_count), .vert_count(vert_count),
    .horz_sync(horz_sync), .vert_sync(vert_sync), .v_on(v_on), .pause(pause),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .frame_count(frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input bit hs, input bit vs, input bit on);
    horz_count = 12'(h);
    vert_count = 12'(v);
    horz_sync  = hs;
    vert_sync  = vs;
    v_on       = on;
  endtask

  task automatic step();
    @(posedge pll_clk);
    #1;
  endtask

  task automatic idle_drive();
    drive(700, 10, 1'b1, 1'b1, 1'b0);
  endtask

  // Bounce rule for one axis, straight from the motion description.
  task automatic axis_move(inout int p, inout bit d, input int act);
    if (!d) begin
      if (p + ST + BS >= act) begin p = act - BS; d = 1'b1; end
      else p = p + ST;
    end else begin
      if (p <= ST) begin p = 0; d = 1'b0; end
      else p = p - ST;
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mdx = 1'b0; mdy = 1'b0; mfc = 0;
  endtask

  // Holds the tick coordinate for n consecutive cycles: one tick per cycle.
  task automatic ticks(input int n);
    drive(0, VA, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      step();
      mfc = (mfc + 1) % 65536;
      if (!pause) begin
        axis_move(mx, mdx, HA);
        axis_move(my, mdy, VA);
      end
    end
    idle_drive();
    step();
  endtask

  task automatic probe(input string tag, input int x, input int y);
    logic [23:0] exp;
    exp = (x >= mx && x < mx + BS && y >= my && y < my + BS) ? FG : BG;
    drive(x, y, 1'b1, 1'b1, 1'b1);
    step();
    idle_drive();
    step();
    chk(tag, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp});
  endtask

  task automatic check_box(input string tag);
    probe({tag, "_tl"}, mx, my);
    probe({tag, "_br"}, mx + BS - 1, my + BS - 1);
    if (mx > 0) probe({tag, "_left"}, mx - 1, my);
    if (mx + BS < HA) probe({tag, "_right"}, mx + BS, my);
    if (my > 0) probe({tag, "_above"}, mx, my - 1);
    if (my + BS < VA) probe({tag, "_below"}, mx, my + BS);
    chk({tag, "_fc"}, 32'(frame_count), 32'(mfc));
  endtask

  initial begin
    pause = 1'b0;
    model_reset();

    // Outputs while reset is held
    reset_P = 1'b1;
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    chk("rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("rst_blank", 32'(VGA_BLANK_N), 32'h0);
    chk("rst_hs", 32'(VGA_HS), 32'h1);
    chk("rst_vs", 32'(VGA_VS), 32'h1);
    chk("rst_fc", 32'(frame_count), 32'h0);
    reset_P = 1'b0;
    idle_drive();
    step();

    probe("px_0_0", 0, 0);
    chk("px_0_0_const", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFF00);
    probe("px_32_0", 32, 0);
    chk("px_32_0_const", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h000040);

    // One-cycle sync/blank pulse must surface exactly 2 edges later
    idle_drive(); step(); step();
    drive(100, 100, 1'b0, 1'b1, 1'b1);
    step();
    chk("lat1_hs", 32'(VGA_HS), 32'h1);
    chk("lat1_blank", 32'(VGA_BLANK_N), 32'h0);
    idle_drive();
    step();
    chk("lat2_hs", 32'(VGA_HS), 32'h0);
    chk("lat2_blank", 32'(VGA_BLANK_N), 32'h1);
    chk("lat2_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h000040);
    step();
    chk("lat3_hs", 32'(VGA_HS), 32'h1);
    chk("lat3_blank", 32'(VGA_BLANK_N), 32'h0);
    chk("lat3_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);

    // Right bounce lands at x=608 on tick 304
    ticks(304);
    probe("bounce_608_in", 608, my);
    chk("bounce_608_in_const", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFF00);
    probe("bounce_607_out", 607, my);
    chk("bounce_607_out_const", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h000040);
    check_box("t304");
    ticks(1);
    probe("t305_606", 606, my);
    chk("t305_606_const", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFF00);
    check_box("t305");

    // Walk to x=2 moving left, then one tick bounces to 0 and reverses
    while (!(mx == 2 && mdx)) ticks(1);
    check_box("pre_left");
    ticks(1);
    probe("left_0", 0, my);
    chk("left_0_const", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFF00);
    check_box("left_bounce");
    ticks(1);
    check_box("left_reverse");

    // Pause across three ticks, then resume
    pause = 1'b1;
    for (int i = 0; i < 3; i++) ticks(1);
    check_box("paused3");
    pause = 1'b0;
    ticks(1);
    check_box("resume");
    // pause raised only between ticks does not freeze motion
    pause = 1'b1;
    idle_drive(); step();
    pause = 1'b0;
    ticks(1);
    check_box("pause_between");

    // Randomized pause patterns and pixel probes
    for (int r = 0; r < 20; r++) begin
      pause = 1'($urandom_range(0, 1));
      ticks(int'($urandom_range(1, 40)));
      pause = 1'b0;
      for (int k = 0; k < 3; k++)
        probe("rand_px", int'($urandom_range(0, HA - 1)), int'($urandom_range(0, VA - 1)));
      probe("rand_near", mx + int'($urandom_range(0, BS)) - 1 < 0 ? 0 : mx + int'($urandom_range(0, BS)) - 1, my);
      check_box("rand");
    end

    // frame_count wraps back to 0 after 65536 ticks
    ticks(65536 - mfc);
    chk("wrap_fc", 32'(frame_count), 32'h0);
    check_box("wrap");

    // Mid-frame reset, then first tick moves from (0,0)
    ticks(5);
    drive(50, 100, 1'b1, 1'b1, 1'b1);
    reset_P = 1'b1;
    step();
    reset_P = 1'b0;
    model_reset();
    idle_drive(); step();
    chk("midrst_fc", 32'(frame_count), 32'h0);
    check_box("midrst");
    ticks(1);
    probe("midrst_2_2", 2, 2);
    chk("midrst_2_2_const", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFF00);
    probe("midrst_1_2", 1, 2);
    check_box("midrst_tick");

    // Reset coinciding with a tick wins
    ticks(3);
    drive(0, VA, 1'b1, 1'b0, 1'b0);
    reset_P = 1'b1;
    step();
    reset_P = 1'b0;
    model_reset();
    idle_drive(); step();
    chk("rst_tick_fc", 32'(frame_count), 32'h0);
    check_box("rst_tick");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
